// File: rtl/keypad_code_entry_pkg.sv
// Shared types and constants for the keypad code-entry block: FSM states,
// special key codes and the width of the presented access code.
package keypad_code_entry_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_CHECK,
    ST_OPEN,
    ST_LOCKOUT
  } state_t;

  localparam logic [3:0] KEY_CLEAR = 4'd10;
  localparam logic [3:0] KEY_ENTER = 4'd11;
  localparam int         CODE_W    = 12;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/keypad_code_entry_interval_timer.sv
// Loadable down-counter that stops at zero; shared by all timed states.
module interval_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] value,
  output logic             done
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (value != '0) begin
      value <= value - 1'b1;
    end
  end

  assign done = (value == '0);

endmodule

// File: rtl/keypad_code_entry.sv
// Keypad code entry: collects up to three decimal digits, presents the code
// for a one-cycle check, then drives door release or a lockout alarm.
module keypad_code_entry
  import keypad_code_entry_pkg::*;
#(
  parameter int TIMEOUT_CYCLES   = 1000,
  parameter int DOOR_OPEN_CYCLES = 200,
  parameter int MAX_FAILS        = 3,
  parameter int LOCKOUT_CYCLES   = 5000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  input  logic [3:0]        key_val,
  input  logic              door_granted,
  output logic [CODE_W-1:0] access_code,
  output logic              code_valid,
  output logic              door_open,
  output logic              alarm,
  output logic [1:0]        digit_cnt
);

  localparam int MAX_IV = max3(TIMEOUT_CYCLES, DOOR_OPEN_CYCLES, LOCKOUT_CYCLES);
  localparam int CNT_W  = $clog2(MAX_IV) + 1;
  localparam int FAIL_W = $clog2(MAX_FAILS + 1);

  localparam logic [CNT_W-1:0]  TIMEOUT_LD = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  OPEN_LD    = CNT_W'(DOOR_OPEN_CYCLES - 1);
  localparam logic [CNT_W-1:0]  LOCK_LD    = CNT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [FAIL_W-1:0] FAIL_LIMIT = FAIL_W'(MAX_FAILS);

  state_t            state;
  logic [9:0]        acc;
  logic [FAIL_W-1:0] fail_cnt;
  logic [FAIL_W-1:0] fail_next;

  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_load_val;
  logic [CNT_W-1:0]  tmr_value;
  logic              tmr_done;

  logic is_digit;
  logic entry_live;
  logic digit_take;

  assign is_digit   = key_valid && (key_val <= 4'd9);
  // A key arriving on the expiry edge is dropped together with the entry.
  assign entry_live = (tmr_value != '0);
  assign digit_take = entry_live && is_digit && (digit_cnt != 2'd3);
  assign fail_next  = fail_cnt + 1'b1;

  interval_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .load_val(tmr_load_val),
    .value   (tmr_value),
    .done    (tmr_done)
  );

  always_comb begin
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    case (state)
      ST_IDLE: begin
        if (is_digit) begin
          tmr_load     = 1'b1;
          tmr_load_val = TIMEOUT_LD;
        end
      end
      ST_ENTRY: begin
        if (digit_take) begin
          tmr_load     = 1'b1;
          tmr_load_val = TIMEOUT_LD;
        end
      end
      ST_CHECK: begin
        if (door_granted) begin
          tmr_load     = 1'b1;
          tmr_load_val = OPEN_LD;
        end else if (fail_next == FAIL_LIMIT) begin
          tmr_load     = 1'b1;
          tmr_load_val = LOCK_LD;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      acc         <= '0;
      digit_cnt   <= '0;
      fail_cnt    <= '0;
      access_code <= '0;
      code_valid  <= 1'b0;
      door_open   <= 1'b0;
      alarm       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (is_digit) begin
            acc       <= {6'b0, key_val};
            digit_cnt <= 2'd1;
            state     <= ST_ENTRY;
          end
        end
        ST_ENTRY: begin
          if (tmr_done) begin
            acc       <= '0;
            digit_cnt <= '0;
            state     <= ST_IDLE;
          end else if (key_valid && key_val == KEY_CLEAR) begin
            acc       <= '0;
            digit_cnt <= '0;
            state     <= ST_IDLE;
          end else if (key_valid && key_val == KEY_ENTER) begin
            access_code <= {2'b0, acc};
            code_valid  <= 1'b1;
            acc         <= '0;
            digit_cnt   <= '0;
            state       <= ST_CHECK;
          end else if (digit_take) begin
            acc       <= 10'(acc * 10'd10) + {6'b0, key_val};
            digit_cnt <= digit_cnt + 2'd1;
          end
        end
        ST_CHECK: begin
          code_valid <= 1'b0;
          if (door_granted) begin
            fail_cnt  <= '0;
            door_open <= 1'b1;
            state     <= ST_OPEN;
          end else if (fail_next == FAIL_LIMIT) begin
            fail_cnt <= fail_next;
            alarm    <= 1'b1;
            state    <= ST_LOCKOUT;
          end else begin
            fail_cnt <= fail_next;
            state    <= ST_IDLE;
          end
        end
        ST_OPEN: begin
          if (tmr_done) begin
            door_open <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        ST_LOCKOUT: begin
          if (tmr_done) begin
            alarm    <= 1'b0;
            fail_cnt <= '0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_code_entry.sv
// Directed bench for keypad_code_entry with default interval parameters.
module tb_keypad_code_entry;
  import keypad_code_entry_pkg::*;

  logic        clk;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_val;
  logic        door_granted;
  logic [11:0] access_code;
  logic        code_valid;
  logic        door_open;
  logic        alarm;
  logic [1:0]  digit_cnt;

  logic        grant_en;
  logic [11:0] grant_code;

  int total;
  int bad;

  assign door_granted = grant_en && (access_code == grant_code);

  keypad_code_entry dut (
    .clk         (clk),
    .rst         (rst),
    .key_valid   (key_valid),
    .key_val     (key_val),
    .door_granted(door_granted),
    .access_code (access_code),
    .code_valid  (code_valid),
    .door_open   (door_open),
    .alarm       (alarm),
    .digit_cnt   (digit_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key_val   = k;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    key_valid = 1'b0;
    key_val = 4'd0;
    grant_en = 1'b0;
    grant_code = 12'd0;
    repeat (3) @(negedge clk);
    total++;
    if ({code_valid, door_open, alarm} !== 3'b000) begin
      bad++; $display("FAIL reset_flags got=%b want=000", {code_valid, door_open, alarm});
    end
    total++;
    if (access_code !== 12'd0 || digit_cnt !== 2'd0) begin
      bad++; $display("FAIL reset_regs code=%0d cnt=%0d want 0/0", access_code, digit_cnt);
    end
    rst = 1'b0;
    press(4'd13);
    press(KEY_ENTER);
    total++;
    if (code_valid !== 1'b0 || digit_cnt !== 2'd0 || dut.state !== ST_IDLE) begin
      bad++; $display("FAIL idle_ignore cv=%b cnt=%0d state=%0d want 0/0/IDLE", code_valid, digit_cnt, dut.state);
    end
  endtask

  task automatic test_open();
    int n;
    grant_en = 1'b1;
    grant_code = 12'd731;
    press(4'd7);
    total++;
    if (digit_cnt !== 2'd1) begin bad++; $display("FAIL open_cnt1 got=%0d want=1", digit_cnt); end
    press(4'd3);
    press(4'd1);
    total++;
    if (digit_cnt !== 2'd3) begin bad++; $display("FAIL open_cnt3 got=%0d want=3", digit_cnt); end
    press(KEY_ENTER);
    total++;
    if (code_valid !== 1'b1 || access_code !== 12'd731) begin
      bad++; $display("FAIL open_code cv=%b code=%0d want 1/731", code_valid, access_code);
    end
    @(negedge clk);
    total++;
    if (code_valid !== 1'b0 || door_open !== 1'b1) begin
      bad++; $display("FAIL open_start cv=%b door=%b want 0/1", code_valid, door_open);
    end
    n = 0;
    while (door_open === 1'b1 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (n != 200) begin bad++; $display("FAIL open_len got=%0d want=200", n); end
    total++;
    if (dut.state !== ST_IDLE || access_code !== 12'd731) begin
      bad++; $display("FAIL open_end state=%0d code=%0d want IDLE/731", dut.state, access_code);
    end
    grant_en = 1'b0;
  endtask

  task automatic test_lockout();
    int n;
    int cv_seen;
    for (int i = 1; i <= 3; i++) begin
      press(4'd1);
      press(4'd2);
      press(4'd3);
      press(KEY_ENTER);
      total++;
      if (code_valid !== 1'b1 || access_code !== 12'd123) begin
        bad++; $display("FAIL lock_code%0d cv=%b code=%0d want 1/123", i, code_valid, access_code);
      end
      @(negedge clk);
      total++;
      if (int'(dut.fail_cnt) != i) begin
        bad++; $display("FAIL lock_fail%0d got=%0d want=%0d", i, dut.fail_cnt, i);
      end
      total++;
      if (alarm !== (i == 3)) begin
        bad++; $display("FAIL lock_alarm%0d got=%b want=%b", i, alarm, (i == 3));
      end
    end
    n = 0;
    cv_seen = 0;
    while (alarm === 1'b1 && n < 6000) begin
      if (code_valid === 1'b1) cv_seen++;
      key_valid = ((n % 50) == 10);
      key_val = 4'((n / 50) % 12);
      n++;
      @(negedge clk);
    end
    key_valid = 1'b0;
    total++;
    if (n != 5000) begin bad++; $display("FAIL lock_len got=%0d want=5000", n); end
    total++;
    if (cv_seen != 0) begin bad++; $display("FAIL lock_keys cv_pulses=%0d want=0", cv_seen); end
    total++;
    if (dut.fail_cnt !== 2'd0 || dut.state !== ST_IDLE || digit_cnt !== 2'd0) begin
      bad++; $display("FAIL lock_end fail=%0d state=%0d cnt=%0d want 0/IDLE/0", dut.fail_cnt, dut.state, digit_cnt);
    end
  endtask

  task automatic test_timeout();
    press(4'd2);
    press(4'd9);
    repeat (999) @(negedge clk);
    total++;
    if (digit_cnt !== 2'd2 || dut.state !== ST_ENTRY) begin
      bad++; $display("FAIL tmo_before cnt=%0d state=%0d want 2/ENTRY", digit_cnt, dut.state);
    end
    @(negedge clk);
    total++;
    if (digit_cnt !== 2'd0 || dut.state !== ST_IDLE) begin
      bad++; $display("FAIL tmo_expire cnt=%0d state=%0d want 0/IDLE", digit_cnt, dut.state);
    end
    press(4'd4);
    press(KEY_ENTER);
    total++;
    if (code_valid !== 1'b1 || access_code !== 12'd4) begin
      bad++; $display("FAIL tmo_code cv=%b code=%0d want 1/4", code_valid, access_code);
    end
    @(negedge clk);
    total++;
    if (dut.fail_cnt !== 2'd1) begin bad++; $display("FAIL tmo_fail got=%0d want=1", dut.fail_cnt); end
  endtask

  task automatic test_clear();
    press(4'd3);
    press(4'd3);
    total++;
    if (digit_cnt !== 2'd2) begin bad++; $display("FAIL clr_pre got=%0d want=2", digit_cnt); end
    press(KEY_CLEAR);
    total++;
    if (digit_cnt !== 2'd0 || dut.state !== ST_IDLE || dut.fail_cnt !== 2'd1) begin
      bad++; $display("FAIL clr_post cnt=%0d state=%0d fail=%0d want 0/IDLE/1", digit_cnt, dut.state, dut.fail_cnt);
    end
    press(4'd1);
    press(4'd9);
    press(4'd1);
    press(KEY_ENTER);
    total++;
    if (code_valid !== 1'b1 || access_code !== 12'd191) begin
      bad++; $display("FAIL clr_code cv=%b code=%0d want 1/191", code_valid, access_code);
    end
    @(negedge clk);
  endtask

  task automatic test_fourth_digit();
    int n;
    grant_en = 1'b1;
    grant_code = 12'd294;
    press(4'd2);
    press(4'd9);
    press(4'd4);
    press(4'd8);
    total++;
    if (digit_cnt !== 2'd3) begin bad++; $display("FAIL dig4_cnt got=%0d want=3", digit_cnt); end
    press(KEY_ENTER);
    total++;
    if (code_valid !== 1'b1 || access_code !== 12'd294) begin
      bad++; $display("FAIL dig4_code cv=%b code=%0d want 1/294", code_valid, access_code);
    end
    @(negedge clk);
    total++;
    if (door_open !== 1'b1 || dut.fail_cnt !== 2'd0) begin
      bad++; $display("FAIL dig4_grant door=%b fail=%0d want 1/0", door_open, dut.fail_cnt);
    end
    n = 0;
    while (door_open === 1'b1 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (n != 200) begin bad++; $display("FAIL dig4_open_len got=%0d want=200", n); end
    grant_en = 1'b0;
  endtask

  task automatic test_reset_in_lockout();
    int n;
    for (int i = 0; i < 3; i++) begin
      press(4'd5);
      press(4'd5);
      press(KEY_ENTER);
      @(negedge clk);
    end
    total++;
    if (alarm !== 1'b1) begin bad++; $display("FAIL rl_alarm_on got=%b want=1", alarm); end
    repeat (100) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (alarm !== 1'b0 || dut.state !== ST_IDLE || dut.fail_cnt !== 2'd0 || access_code !== 12'd0) begin
      bad++; $display("FAIL rl_async alarm=%b state=%0d fail=%0d code=%0d want 0/IDLE/0/0", alarm, dut.state, dut.fail_cnt, access_code);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    grant_en = 1'b1;
    grant_code = 12'd731;
    key_valid = 1'b1;
    key_val = 4'd7;
    @(negedge clk);
    key_valid = 1'b0;
    total++;
    if (digit_cnt !== 2'd1 || alarm !== 1'b0) begin
      bad++; $display("FAIL rl_first_key cnt=%0d alarm=%b want 1/0", digit_cnt, alarm);
    end
    press(4'd3);
    press(4'd1);
    press(KEY_ENTER);
    total++;
    if (code_valid !== 1'b1 || access_code !== 12'd731) begin
      bad++; $display("FAIL rl_code cv=%b code=%0d want 1/731", code_valid, access_code);
    end
    @(negedge clk);
    total++;
    if (door_open !== 1'b1 || alarm !== 1'b0) begin
      bad++; $display("FAIL rl_open door=%b alarm=%b want 1/0", door_open, alarm);
    end
    n = 0;
    while (door_open === 1'b1 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (n != 200) begin bad++; $display("FAIL rl_open_len got=%0d want=200", n); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_open();
    test_lockout();
    test_timeout();
    test_clear();
    test_fourth_digit();
    test_reset_in_lockout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_code_entry.md
KEYPAD_CODE_ENTRY -- requirements
Module: keypad_code_entry

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000: idle cycles allowed between keys before a partial entry is abandoned.
REQ-002 Parameter DOOR_OPEN_CYCLES, default 200: cycles door_open stays high after a granted code.
REQ-003 Parameter MAX_FAILS, default 3: consecutive rejected codes that trigger lockout.
REQ-004 Parameter LOCKOUT_CYCLES, default 5000: lockout duration in cycles.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 key_valid  input  1  one-cycle strobe; key_val is valid this cycle.
REQ-008 key_val  input  4  key code: 0-9 digit, 10 = clear (*), 11 = enter (#), 12-15 ignored.
REQ-009 door_granted  input  1  combinational match result from the access checker for access_code; sampled only while code_valid=1.
REQ-010 access_code  output  12  binary value of the entered 3-digit decimal code, zero-extended.
REQ-011 code_valid  output  1  one-cycle qualifier for access_code.
REQ-012 door_open  output  1  door release.
REQ-013 alarm  output  1  high throughout lockout.
REQ-014 digit_cnt  output  2  digits accepted in the current entry, 0-3.

Function
REQ-015 The FSM SHALL have the states IDLE, ENTRY, CHECK, OPEN and LOCKOUT, and SHALL reset to IDLE.
REQ-016 IDLE: a digit key SHALL load acc=digit and digit_cnt=1, then go to ENTRY; all other keys SHALL be ignored.
REQ-017 ENTRY, digit with digit_cnt<3: acc SHALL become acc*10+digit and digit_cnt SHALL increment; acc is 10 bits wide, max 999.
REQ-018 ENTRY, digit with digit_cnt=3: the digit SHALL be ignored, with no change to acc, digit_cnt or the timer.
REQ-019 ENTRY, clear key: acc and digit_cnt SHALL go to 0, the FSM SHALL go to IDLE, and fail_cnt SHALL be unchanged.
REQ-020 ENTRY, enter key: access_code SHALL load {2'b0,acc}, and the FSM SHALL go to CHECK on the next cycle.
REQ-021 An enter key with digit_cnt<3 SHALL still be checked; its short value is presented as-is.
REQ-022 ENTRY timer SHALL reset on every accepted key_valid; after TIMEOUT_CYCLES cycles with no key the FSM SHALL go to IDLE, clear acc and digit_cnt, and leave fail_cnt unchanged.
REQ-023 CHECK SHALL last exactly 1 cycle with code_valid=1; latency from the enter strobe to code_valid is 1 cycle.
REQ-024 CHECK with door_granted=1: fail_cnt SHALL be set to 0 and the FSM SHALL go to OPEN.
REQ-025 CHECK with door_granted=0: fail_cnt SHALL increment; if the new value equals MAX_FAILS the FSM SHALL go to LOCKOUT, else to IDLE.
REQ-026 OPEN: door_open SHALL be 1 for exactly DOOR_OPEN_CYCLES cycles, then the FSM SHALL go to IDLE.
REQ-027 LOCKOUT: alarm SHALL be 1 for exactly LOCKOUT_CYCLES cycles, then fail_cnt SHALL clear and the FSM SHALL go to IDLE.
REQ-028 All keys SHALL be ignored in CHECK, OPEN and LOCKOUT; a key strobe coincident with a state exit SHALL also be ignored.
REQ-029 door_granted SHALL be ignored outside CHECK.
REQ-030 access_code SHALL hold its last loaded value between checks.
REQ-031 digit_cnt SHALL read 0 in every state except ENTRY.
REQ-032 All outputs SHALL be registered.
REQ-033 A single shared down-counter SHALL serve the timeout, door-open and lockout intervals; it is reloaded on each state entry.
REQ-034 The counter width SHALL be $clog2 of the largest interval parameter plus 1.

Reset
REQ-035 rst=1 SHALL immediately force state=IDLE and acc, digit_cnt, fail_cnt, counter and access_code to 0.
REQ-036 rst=1 SHALL immediately force code_valid, door_open and alarm to 0.
REQ-037 Reset during OPEN or LOCKOUT SHALL abort the interval with no residual pulse after release.
REQ-038 The first key SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-039 A shared package SHALL hold the state enum, the key codes KEY_CLEAR=10 and KEY_ENTER=11, and the 12-bit code width.
REQ-040 One sub-module, interval_timer, SHALL implement the loadable down-counter with load, value and done ports; all other logic SHALL be inline.

Verification
REQ-041 Keys 7,3,1,# with door_granted tied to (access_code==731) -> access_code=12'd731 with code_valid=1 for 1 cycle, door_open=1 for exactly 200 cycles, then IDLE.
REQ-042 Three entries of 1,2,3,# with door_granted=0 -> fail_cnt goes 1,2,3; alarm=1 for exactly 5000 cycles; keys sent during that time produce no code_valid.
REQ-043 Keys 2,9 then 1000 idle cycles, then 4,# -> digit_cnt returns to 0 at the timeout; the check presents 12'd4.
REQ-044 Keys 3,3,*,1,9,1,# -> the clear key empties the entry; access_code=12'd191 is presented.
REQ-045 Keys 2,9,4,8,# -> the 4th digit is ignored; access_code=12'd294.
REQ-046 rst asserted in mid-LOCKOUT at cycle 100 -> alarm drops asynchronously; after release, 7,3,1,# is accepted normally.
